mmc_cmd_engine: RTL and testbench
=================================

# mmc_cmd_engine

Host-side MMC/SD command-line engine. It generates the card clock, serialises a 48-bit command frame with CRC7 onto the CMD line, and optionally captures and checks a 48-bit response. It drives the pad-level tristate controls of the MMC CMD pin infrastructure and sits between that pad wrapper and the controller logic that issues card commands.

## Interface
- CLK_DIV, default 2: mmc_clk half-period in clk cycles; legal values are 1 or greater.
- RESP_TIMEOUT, default 64: maximum number of mmc_clk rising edges to wait for a response start bit.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_start  in  1  request pulse; honoured only while busy=0.
- cmd_index  in  6  command index; latched on accept.
- cmd_arg  in  32  command argument; latched on accept.
- resp_en  in  1  expect a 48-bit response; latched on accept.
- resp_crc_chk  in  1  check the response CRC7; latched on accept. Set to 0 for R3.
- busy  out  1  transaction in progress.
- done  out  1  one-clk pulse at end of transaction.
- resp_index  out  6  received bits [45:40].
- resp_arg  out  32  received bits [39:8].
- timeout  out  1  no response start bit seen.
- crc_err  out  1  CRC7, transmission-bit or end-bit error.
- mmc_clk  out  1  card clock.
- cmd_out  out  1  value to drive on CMD; connects to the pad output-data input.
- cmd_oe  out  1  CMD output enable.
- cmd_in  in  1  CMD pin value from the pad input buffer.

## Operation
- The divider counter is ceil(log2(CLK_DIV)) bits wide or more.
  - mmc_clk toggles every CLK_DIV clk cycles and runs continuously, including in IDLE.
  - Fall tick: the cycle in which mmc_clk goes 1->0. Rise tick: the cycle in which it goes 0->1.
- cmd_out and cmd_oe change only on fall ticks. cmd_in is sampled only on rise ticks.
- TX frame, MSB first: 0, 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], 1.
  - CRC7 uses polynomial x^7+x^3+1 with initial value 0.
  - It is computed over the first 40 bits.
- States:
  - IDLE: on cmd_start, latch inputs, clear timeout/crc_err/resp_*, go to TX.
  - TX: at each fall tick, drive the next bit with cmd_oe=1. At the fall tick after the end bit, set cmd_oe=0 and cmd_out=1. Go to WAIT if resp_en, else GAP.
  - WAIT: count rise ticks.
    - cmd_in=0 sampled -> RX; this start bit is counted as bit 47.
    - RESP_TIMEOUT rise ticks without a 0 -> timeout=1, go to GAP.
  - RX: shift 47 further bits on rise ticks. After the end bit:
    - crc_err=1 if bit46≠0, or bit0≠1, or (resp_crc_chk and received CRC ≠ CRC7 of bits [47:8]).
    - Load resp_index and resp_arg, then go to GAP.
  - GAP: 8 rise ticks (Ncc), then done=1 for one clk, busy=0, IDLE.
- cmd_start while busy=1 is ignored; no queueing.
- resp_*, timeout and crc_err hold from done until the next accept.
- rst in any state: IDLE immediately, with the divider restarted and all outputs at reset values. A partial frame is abandoned and there is no done pulse.

## Timing
- Reset values:
  - mmc_clk=0, cmd_out=1, cmd_oe=0.
  - busy=0, done=0, timeout=0, crc_err=0, resp_index=0, resp_arg=0.
- Accept at clk edge N: busy=1 from cycle N+1. The start bit is driven at the first fall tick after N+1.
- Each bit is held for one full mmc_clk period (2·CLK_DIV clk cycles).
- The card samples on mmc_clk rising edges; setup is CLK_DIV clk cycles.
- A response start bit is recognised no earlier than the 2nd rise tick after cmd_oe drops (Ncr ≥ 2). A 0 on the 1st rise tick is ignored.
- done and busy=0 occur in the same clk cycle, one cycle after the 8th GAP rise tick.
- Transaction length with no response: 49 + 8 mmc_clk periods plus alignment, at most one extra period.

## Test plan
- CMD0, arg 0, resp_en=0, CLK_DIV=2:
  - cmd_out sequence equals 0x400000000095, with each bit stable across its rising edge.
  - cmd_oe is high for exactly 48 periods.
  - done pulses once and timeout=0.
- CMD8, arg 0x000001AA, resp_en=1, resp_crc_chk=1:
  - TX frame is 0x48000001AA87.
  - Model replies 0x08000001AA13 after 5 periods -> resp_index=8, resp_arg=0x000001AA, crc_err=0, timeout=0.
- Same response with one argument bit flipped -> crc_err=1.
- Same with resp_crc_chk=0 -> crc_err=0.
- resp_en=1, cmd_in held at 1 -> timeout=1 after 64 rise ticks. done follows 8 rise ticks later, and resp_arg=0.
- cmd_start re-pulsed mid-TX -> ignored, and the frame is unchanged.
- rst asserted at bit 20 -> cmd_oe=0, cmd_out=1, busy=0 the next cycle, with no done. A new command afterwards transmits correctly.

Source files
------------

// File: rtl/mmc_cmd_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : mmc_cmd_engine_if
// Brief    : Controller handshake and CMD pad bundle for mmc_cmd_engine.
// Revision : 1.0 - initial release
// ============================================================================
interface mmc_cmd_engine_if;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_en;
    logic        resp_crc_chk;
    logic        busy;
    logic        done;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        timeout;
    logic        crc_err;
    logic        mmc_clk;
    logic        cmd_out;
    logic        cmd_oe;
    logic        cmd_in;

    // Master is the controller plus the pad input buffer; slave is the engine.
    modport master (
        output cmd_start, cmd_index, cmd_arg, resp_en, resp_crc_chk, cmd_in,
        input  busy, done, resp_index, resp_arg, timeout, crc_err,
        input  mmc_clk, cmd_out, cmd_oe
    );

    modport slave (
        input  cmd_start, cmd_index, cmd_arg, resp_en, resp_crc_chk, cmd_in,
        output busy, done, resp_index, resp_arg, timeout, crc_err,
        output mmc_clk, cmd_out, cmd_oe
    );
endinterface
`default_nettype wire

// File: rtl/mmc_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : mmc_cmd_engine
// Brief    : MMC/SD host CMD-line engine: card clock, CRC7 command framing,
//            response capture and check.
// Revision : 1.0 - initial release
// ============================================================================
module mmc_cmd_engine #(
    parameter int CLK_DIV      = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mmc_cmd_engine_if.slave bus
);

    localparam int                DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int                TO_W       = $clog2(RESP_TIMEOUT + 1);
    localparam int                CNT_W      = (TO_W > 6) ? TO_W : 6;
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_TX_LAST  = CNT_W'(48);
    localparam logic [CNT_W-1:0]  C_RX_LAST  = CNT_W'(46);
    localparam logic [CNT_W-1:0]  C_GAP_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0]  C_TO_LAST  = CNT_W'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_WAIT = 3'd2,
        ST_RX   = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    function automatic logic [6:0] crc7_40(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
        end
        return crc;
    endfunction

    logic [DIV_W-1:0] div_cnt_q;
    logic             mmc_clk_q;
    logic             w_tick;
    logic             w_rise;
    logic             w_fall;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [47:0]      tx_sr_q;
    logic [45:0]      rx_sr_q;
    logic             resp_en_q;
    logic             crc_chk_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic             crc_err_q;
    logic [5:0]       resp_index_q;
    logic [31:0]      resp_arg_q;
    logic             cmd_out_q;
    logic             cmd_oe_q;

    logic [39:0]      w_tx_payload;
    logic [47:0]      w_rx_word;
    logic             w_rx_bad;

    // Free-running card clock; it keeps toggling in IDLE so the card sees Ncc.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            mmc_clk_q <= 1'b0;
        end else if (div_cnt_q == C_DIV_LAST) begin
            div_cnt_q <= '0;
            mmc_clk_q <= ~mmc_clk_q;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    assign w_tick = (div_cnt_q == C_DIV_LAST);
    assign w_rise = w_tick & ~mmc_clk_q;
    assign w_fall = w_tick &  mmc_clk_q;

    assign w_tx_payload = {2'b01, bus.cmd_index, bus.cmd_arg};

    // Start bit is implicit; the final bit comes straight from the pin on the last rise tick.
    assign w_rx_word = {1'b0, rx_sr_q, bus.cmd_in};
    assign w_rx_bad  = w_rx_word[46] | ~w_rx_word[0]
                     | (crc_chk_q & (crc7_40(w_rx_word[47:8]) != w_rx_word[7:1]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tx_sr_q      <= '1;
            rx_sr_q      <= '0;
            resp_en_q    <= 1'b0;
            crc_chk_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            crc_err_q    <= 1'b0;
            resp_index_q <= '0;
            resp_arg_q   <= '0;
            cmd_out_q    <= 1'b1;
            cmd_oe_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_start) begin
                        tx_sr_q      <= {w_tx_payload, crc7_40(w_tx_payload), 1'b1};
                        resp_en_q    <= bus.resp_en;
                        crc_chk_q    <= bus.resp_crc_chk;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        timeout_q    <= 1'b0;
                        crc_err_q    <= 1'b0;
                        resp_index_q <= '0;
                        resp_arg_q   <= '0;
                        state_q      <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (w_fall) begin
                        if (cnt_q == C_TX_LAST) begin
                            cmd_oe_q  <= 1'b0;
                            cmd_out_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= resp_en_q ? ST_WAIT : ST_GAP;
                        end else begin
                            cmd_oe_q  <= 1'b1;
                            cmd_out_q <= tx_sr_q[47];
                            tx_sr_q   <= {tx_sr_q[46:0], 1'b1};
                            cnt_q     <= cnt_q + C_CNT_ONE;
                        end
                    end
                end

                ST_WAIT: begin
                    // cnt_q==0 is the first rise after release, still inside Ncr.
                    if (w_rise) begin
                        if ((cnt_q != '0) && !bus.cmd_in) begin
                            cnt_q   <= '0;
                            state_q <= ST_RX;
                        end else if (cnt_q == C_TO_LAST) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= ST_GAP;
                        end else begin
                            cnt_q <= cnt_q + C_CNT_ONE;
                        end
                    end
                end

                ST_RX: begin
                    if (w_rise) begin
                        rx_sr_q <= {rx_sr_q[44:0], bus.cmd_in};
                        if (cnt_q == C_RX_LAST) begin
                            resp_index_q <= w_rx_word[45:40];
                            resp_arg_q   <= w_rx_word[39:8];
                            crc_err_q    <= w_rx_bad;
                            cnt_q        <= '0;
                            state_q      <= ST_GAP;
                        end else begin
                            cnt_q <= cnt_q + C_CNT_ONE;
                        end
                    end
                end

                ST_GAP: begin
                    if (w_rise) begin
                        if (cnt_q == C_GAP_LAST) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + C_CNT_ONE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mmc_clk    = mmc_clk_q;
    assign bus.cmd_out    = cmd_out_q;
    assign bus.cmd_oe     = cmd_oe_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.crc_err    = crc_err_q;
    assign bus.resp_index = resp_index_q;
    assign bus.resp_arg   = resp_arg_q;

endmodule
`default_nettype wire

// File: tb/tb_mmc_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmc_cmd_engine
// Brief    : Self-checking bench for mmc_cmd_engine with a card-side model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmc_cmd_engine;

    localparam int CLK_DIV      = 2;
    localparam int RESP_TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mmc_cmd_engine_if bus ();

    mmc_cmd_engine #(
        .CLK_DIV      (CLK_DIV),
        .RESP_TIMEOUT (RESP_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // CRC7 as the remainder of msg*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input bit ren, input bit chk, input logic [47:0] exp_frame,
                           input bit reply, input logic [47:0] resp, input int ncr,
                           input bit early0, input int repulse_bit, input int rst_bit);
        logic [47:0] tx_bits;
        int          n_tx, oe_cycles, unstable, rises_after, falls_after, budget, done_rise, dn_cnt;
        bit          oe_dropped, finished, pulsing, prev_mclk, prev_out;
        logic        d_busy, d_to, d_crc;
        logic [5:0]  d_idx;
        logic [31:0] d_arg;
        bit          exp_to, exp_crc;
        logic [5:0]  exp_idx;
        logic [31:0] exp_arg;
        int          exp_rise;

        tx_bits = '0; n_tx = 0; oe_cycles = 0; unstable = 0; rises_after = 0; falls_after = 0;
        budget = 3000; done_rise = -1; oe_dropped = 0; finished = 0; pulsing = 0;
        d_busy = 1'bx; d_to = 1'bx; d_crc = 1'bx; d_idx = 'x; d_arg = 'x;

        exp_to   = ren && !reply;
        exp_idx  = (ren && reply) ? resp[45:40] : 6'd0;
        exp_arg  = (ren && reply) ? resp[39:8]  : 32'd0;
        exp_crc  = ren && reply && (resp[46] || !resp[0] ||
                   (chk && (ref_crc7(resp[47:8]) != resp[7:1])));
        exp_rise = !ren ? 8 : (reply ? ncr + 56 : RESP_TIMEOUT + 8);

        @(negedge clk);
        bus.cmd_index = idx; bus.cmd_arg = arg; bus.resp_en = ren; bus.resp_crc_chk = chk;
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        bus.cmd_index = ~idx; bus.cmd_arg = ~arg; bus.resp_en = ~ren; bus.resp_crc_chk = ~chk;
        check({tag, "_busy_after_accept"}, bus.busy, 1);
        prev_mclk = bus.mmc_clk; prev_out = bus.cmd_out;

        while (!finished && budget > 0) begin
            @(negedge clk);
            budget--;
            if (pulsing) begin bus.cmd_start = 1'b0; pulsing = 0; end
            if (bus.cmd_oe) oe_cycles++;
            if (bus.mmc_clk && !prev_mclk) begin
                if (oe_dropped) rises_after++;
                if (bus.cmd_oe) begin
                    if (bus.cmd_out !== prev_out) unstable++;
                    tx_bits = {tx_bits[46:0], bus.cmd_out};
                    n_tx++;
                    if (n_tx == repulse_bit) begin
                        bus.cmd_start = 1'b1; pulsing = 1;
                    end
                    if (n_tx == rst_bit) begin
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        check({tag, "_rst_oe"},   bus.cmd_oe,  0);
                        check({tag, "_rst_out"},  bus.cmd_out, 1);
                        check({tag, "_rst_busy"}, bus.busy,    0);
                        check({tag, "_rst_tx_prefix"}, tx_bits[19:0], exp_frame[47:28]);
                        dn_cnt = 0;
                        repeat (600) begin
                            @(negedge clk);
                            if (bus.done) dn_cnt++;
                        end
                        check({tag, "_rst_no_done"}, dn_cnt, 0);
                        bus.cmd_in = 1'b1;
                        return;
                    end
                end
            end
            if (!bus.mmc_clk && prev_mclk) begin
                if (oe_dropped) falls_after++;
                else if (n_tx == 48 && !bus.cmd_oe) oe_dropped = 1;
                if (oe_dropped && reply) begin
                    if (falls_after >= ncr && falls_after < ncr + 48)
                        bus.cmd_in = resp[47 - (falls_after - ncr)];
                    else if (early0 && falls_after == 0)
                        bus.cmd_in = 1'b0;
                    else
                        bus.cmd_in = 1'b1;
                end
            end
            if (bus.done) begin
                finished = 1; done_rise = rises_after; d_busy = bus.busy;
                d_to = bus.timeout; d_crc = bus.crc_err; d_idx = bus.resp_index; d_arg = bus.resp_arg;
            end
            prev_mclk = bus.mmc_clk; prev_out = bus.cmd_out;
        end
        bus.cmd_in = 1'b1;

        check({tag, "_done_seen"},   finished, 1);
        check({tag, "_tx_frame"},    tx_bits, exp_frame);
        check({tag, "_oe_cycles"},   oe_cycles, 48 * 2 * CLK_DIV);
        check({tag, "_bit_stable"},  unstable, 0);
        check({tag, "_done_rise"},   done_rise, exp_rise);
        check({tag, "_busy_at_done"}, d_busy, 0);
        check({tag, "_timeout"},     d_to, exp_to);
        check({tag, "_crc_err"},     d_crc, exp_crc);
        check({tag, "_resp_index"},  d_idx, exp_idx);
        check({tag, "_resp_arg"},    d_arg, exp_arg);
        @(negedge clk);
        check({tag, "_done_single"}, bus.done, 0);
        repeat (5) @(negedge clk);
        check({tag, "_resp_hold"},   {bus.resp_index, bus.resp_arg, bus.timeout, bus.crc_err},
                                     {exp_idx, exp_arg, exp_to, exp_crc});
    endtask

    initial begin
        logic [5:0]  r_idx, p_idx;
        logic [31:0] r_arg, p_arg;
        logic [47:0] r_resp;
        bit          r_ren, r_chk, r_reply;

        bus.cmd_start = 1'b0; bus.cmd_index = '0; bus.cmd_arg = '0;
        bus.resp_en = 1'b0; bus.resp_crc_chk = 1'b0; bus.cmd_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pins", {bus.mmc_clk, bus.cmd_out, bus.cmd_oe}, 3'b010);
        check("reset_status", {bus.busy, bus.done, bus.timeout, bus.crc_err}, 4'b0000);
        check("reset_resp", {bus.resp_index, bus.resp_arg}, 38'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn("cmd0", 6'd0, 32'd0, 0, 0, 48'h400000000095, 0, 48'd0, 0, 0, -1, -1);
        run_txn("cmd8", 6'd8, 32'h000001AA, 1, 1, 48'h48000001AA87,
                1, 48'h08000001AA13, 5, 0, -1, -1);
        run_txn("cmd8_flip", 6'd8, 32'h000001AA, 1, 1, 48'h48000001AA87,
                1, 48'h08000001AA13 ^ (48'd1 << 20), 5, 0, -1, -1);
        run_txn("cmd8_flip_nochk", 6'd8, 32'h000001AA, 1, 0, 48'h48000001AA87,
                1, 48'h08000001AA13 ^ (48'd1 << 20), 5, 0, -1, -1);
        run_txn("timeout", 6'd8, 32'h000001AA, 1, 1, 48'h48000001AA87, 0, 48'd0, 0, 0, -1, -1);
        run_txn("ncr_min", 6'd2, 32'h0, 1, 1, ref_frame(6'd2, 32'h0),
                1, 48'h08000001AA13, 1, 0, -1, -1);
        run_txn("ncr_early0", 6'd9, 32'h12340000, 1, 1, ref_frame(6'd9, 32'h12340000),
                1, 48'h08000001AA13, 3, 1, -1, -1);
        run_txn("repulse", 6'd17, 32'hDEADBEEF, 0, 0, ref_frame(6'd17, 32'hDEADBEEF),
                0, 48'd0, 0, 0, 10, -1);
        run_txn("rst_mid", 6'd24, 32'hCAFEF00D, 1, 1, ref_frame(6'd24, 32'hCAFEF00D),
                0, 48'd0, 0, 0, -1, 20);
        run_txn("after_rst", 6'd8, 32'h000001AA, 1, 1, 48'h48000001AA87,
                1, 48'h08000001AA13, 4, 0, -1, -1);

        for (int t = 0; t < 8; t++) begin
            r_idx   = 6'($urandom);
            r_arg   = $urandom;
            r_ren   = 1'($urandom_range(0, 1));
            r_chk   = 1'($urandom_range(0, 1));
            r_reply = r_ren && ($urandom_range(0, 3) != 0);
            p_idx   = 6'($urandom);
            p_arg   = $urandom;
            r_resp  = {2'b00, p_idx, p_arg, ref_crc7({2'b00, p_idx, p_arg}), 1'b1};
            if ($urandom_range(0, 2) == 0) r_resp[$urandom_range(0, 46)] ^= 1'b1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_txn("rnd", r_idx, r_arg, r_ren, r_chk, ref_frame(r_idx, r_arg),
                    r_reply, r_resp, int'($urandom_range(1, 8)), 0, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
